// File: rtl/uncached_bridge.sv
// Uncached data-bus bridge: posts stores into a small write buffer drained as single-beat
// AXI4 writes; loads go out as single-beat AXI4 reads only once every posted store has retired.
module uncached_bridge #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_uc_read,
  input  logic        dbus_uc_write,
  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteen,
  input  logic [31:0] dbus_wrdata,
  output logic        dbus_uc_stall,
  output logic [31:0] dbus_uc_rddata,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awsize,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wlast,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [31:0] axi_araddr,
  output logic [2:0]  axi_arsize,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rvalid,
  input  logic        axi_rlast,
  output logic        axi_rready,
  output logic [1:0]  w_state,
  output logic [2:0]  r_state
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_DRAIN = 3'd1;
  localparam logic [2:0] R_ADDR  = 3'd2;
  localparam logic [2:0] R_DATA  = 3'd3;
  localparam logic [2:0] R_DONE  = 3'd4;

  logic [31:0]      fifo_addr [WBUF_DEPTH];
  logic [2:0]       fifo_size [WBUF_DEPTH];
  logic [3:0]       fifo_strb [WBUF_DEPTH];
  logic [31:0]      fifo_data [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full, fifo_empty, push, pop;
  logic             aw_hs, w_hs, aw_done, w_done, rd_done;
  logic [31:0]      req_addr;
  logic [2:0]       req_size;
  logic             unused_ok;

  // Byte enables select both the AXI size and the low address bits; dbus_address[1:0] is ignored.
  always_comb begin
    req_size = 3'd0;
    req_addr = {dbus_address[31:2], 2'b00};
    case (dbus_byteen)
      4'b1111: req_size = 3'd2;
      4'b0011: req_size = 3'd1;
      4'b1100: begin req_size = 3'd1; req_addr[1:0] = 2'b10; end
      4'b0010: req_addr[1:0] = 2'b01;
      4'b0100: req_addr[1:0] = 2'b10;
      4'b1000: req_addr[1:0] = 2'b11;
      default: req_size = 3'd0;
    endcase
  end

  assign fifo_full     = (count == (PTR_W+1)'(WBUF_DEPTH));
  assign fifo_empty    = (count == '0);
  assign push          = dbus_uc_write & ~fifo_full;
  assign pop           = (w_state == W_RESP) & axi_bvalid;
  assign dbus_uc_stall = (dbus_uc_write & fifo_full) | (dbus_uc_read & ~rd_done);
  assign unused_ok     = &{1'b0, axi_rlast, dbus_address[1:0]};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_size[wr_ptr] <= req_size;
      fifo_strb[wr_ptr] <= dbus_byteen;
      fifo_data[wr_ptr] <= dbus_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Every AXI channel transfers on the edge where valid and ready are both high; a valid,
  // once raised, stays high with a stable payload until that edge. The head entry is the
  // write payload and cannot move until its B response pops it.
  assign axi_awaddr = fifo_addr[rd_ptr];
  assign axi_awsize = fifo_size[rd_ptr];
  assign axi_wdata  = fifo_data[rd_ptr];
  assign axi_wstrb  = fifo_strb[rd_ptr];
  assign axi_wlast  = axi_wvalid;
  assign aw_hs      = axi_awvalid & axi_awready;
  assign w_hs       = axi_wvalid & axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!fifo_empty) begin
            w_state     <= W_REQ;
            axi_awvalid <= 1'b1;
            axi_wvalid  <= 1'b1;
          end
        end
        W_REQ: begin
          if (aw_hs) begin axi_awvalid <= 1'b0; aw_done <= 1'b1; end
          if (w_hs)  begin axi_wvalid  <= 1'b0; w_done  <= 1'b1; end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            w_state    <= W_RESP;
            axi_bready <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end
        end
        W_RESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            if (count > (PTR_W+1)'(1)) begin
              w_state     <= W_REQ;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
            end else begin
              w_state <= W_IDLE;
            end
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Loads wait in R_DRAIN until the buffer is empty and the last B has been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= R_IDLE;
      axi_arvalid    <= 1'b0;
      axi_rready     <= 1'b0;
      axi_araddr     <= '0;
      axi_arsize     <= '0;
      rd_done        <= 1'b0;
      dbus_uc_rddata <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (dbus_uc_read && !rd_done) r_state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (fifo_empty && (w_state == W_IDLE)) begin
            r_state     <= R_ADDR;
            axi_arvalid <= 1'b1;
            axi_araddr  <= req_addr;
            axi_arsize  <= req_size;
          end
        end
        R_ADDR: begin
          if (axi_arready) begin
            r_state     <= R_DATA;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
          end
        end
        R_DATA: begin
          if (axi_rvalid) begin
            r_state        <= R_DONE;
            axi_rready     <= 1'b0;
            rd_done        <= 1'b1;
            dbus_uc_rddata <= axi_rdata;
          end
        end
        R_DONE: begin
          r_state <= R_IDLE;
          rd_done <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dbus_uc_read && dbus_uc_write))
        else $error("uncached_bridge: uncached read and write requested together");
    end
  end
`endif

endmodule
